ps2_key_encoder: RTL

- Receives the raw PS/2 keyboard serial stream (scan code set 2) and encodes it into the 11-bit ps2_key event word that core-side keyboard decoders consume.
- ps2_key layout: [10] toggles once per event, [9] pressed, [8] extended, [7:0] code.
- Lets cores take a physical PS/2 keyboard (e.g. on a user-port adapter) through the same key-decode logic already used for HPS-supplied keys.
- Sits between the PS/2 pins and the core's key-decode always block, in the clk_sys domain.

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_rx_frame.sv | 130 +++++++++++++
 rtl/ps2_key_encoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, ps2_key field positions and frame FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ps2_pkg;

  // Prefix and special bytes of scan code set 2
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard-to-host responses that carry no key information
  localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
  localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

  // Pause is an 8-byte make-only sequence; E1 is followed by 7 more bytes
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  // ps2_key field positions
  localparam int TOG = 10;
  localparam int PRS = 9;
  localparam int EXT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  function automatic logic is_response(input logic [7:0] b);
    return (b == PS2_RSP_BAT)    || (b == PS2_RSP_ACK)  ||
           (b == PS2_RSP_RESEND) || (b == PS2_RSP_ECHO) ||
           (b == PS2_RSP_ERR0)   || (b == PS2_RSP_ERR1);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line receiver: synchronize, glitch-filter ps2_clk, deframe 11-bit frames, check parity/stop/timeout.
// Latency: byte_rdy pulses one cycle after the cycle in which the stop-bit fall is seen.
// Backpressure: none; byte_rdy and frame_err are single-cycle pulses the consumer must take.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_rdy,
  output logic [7:0] byte_dat,
  output logic       frame_err
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_s1, clk_s2;
  logic             dat_s1, dat_s2;
  logic             filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall;
  logic             dat_smp;

  frame_state_e     state;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             par;
  logic [TO_W-1:0]  idle_cnt;

  // Two-flop synchronizers; idle PS/2 lines float high, so reset to 1
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level flips after FILTER_LEN consecutive differing samples; fall pulses with the 1->0 flip
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt    <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
      dat_smp <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        filt    <= clk_s2;
        flt_cnt <= '0;
        fall    <= filt;
        dat_smp <= dat_s2;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM with idle timeout; a fall in the same cycle as a timeout wins
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      byte_rdy  <= 1'b0;
      byte_dat  <= '0;
      frame_err <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (state)
          ST_IDLE: begin
            // A high start bit is line noise; ignore it silently
            if (!dat_smp) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg  <= {dat_smp, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= dat_smp;
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (dat_smp && (^{par, shreg})) begin
              byte_rdy <= 1'b1;
              byte_dat <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (idle_cnt == TO_W'(TIMEOUT_CYCLES)) begin
          state     <= ST_IDLE;
          frame_err <= 1'b1;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 stream to 11-bit ps2_key event word {toggle, pressed, extended, code}; optional PS2_TYPEMATIC_FILTER_EN.
// Latency: ps2_key/key_strobe update 2 clk_sys cycles after the stop-bit fall is detected.
// Backpressure: none; key_strobe and frame_err are single-cycle pulses.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  logic       byte_vld;
  logic [7:0] byte_dat;
  logic       rx_err;

  logic       ext_f, brk_f;
  logic [2:0] skip;

  logic       dec_emit;
  logic       dec_ext;
  logic       dec_prs;
  logic [7:0] dec_code;
  logic       suppress;
  logic       emit_fire;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_rdy  (byte_vld),
    .byte_dat  (byte_dat),
    .frame_err (rx_err)
  );

  assign frame_err = rx_err;

  // Classify the received byte: prefix, response, Pause tail, or a key event
  always_comb begin
    dec_emit = 1'b0;
    dec_ext  = ext_f;
    dec_prs  = ~brk_f;
    dec_code = byte_dat;
    if (byte_vld && !rx_err) begin
      if (skip != 3'd0) begin
        // Last byte of the Pause sequence stands in for the whole key
        if (skip == 3'd1) begin
          dec_emit = 1'b1;
          dec_ext  = 1'b1;
          dec_prs  = 1'b1;
          dec_code = PAUSE_CODE;
        end
      end else if ((byte_dat != PS2_EXT) && (byte_dat != PS2_BRK) && (byte_dat != PS2_PAUSE)) begin
        dec_emit = !(is_response(byte_dat) && !ext_f && !brk_f);
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] held;

  // Auto-repeat makes of an already-held key are swallowed; Pause never is
  assign suppress = dec_emit && (skip == 3'd0) && dec_prs && held[{dec_ext, dec_code}];

  // Track which {ext, code} keys are currently down
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      held <= '0;
    end else if (dec_emit && (skip == 3'd0)) begin
      held[{dec_ext, dec_code}] <= dec_prs;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign emit_fire = dec_emit && !suppress;

  // Prefix flags, Pause skip counter and the registered event word
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_f      <= 1'b0;
      brk_f      <= 1'b0;
      skip       <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (emit_fire) begin
        ps2_key    <= {~ps2_key[TOG], dec_prs, dec_ext, dec_code};
        key_strobe <= 1'b1;
      end
      if (rx_err) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (byte_vld) begin
        if (skip != 3'd0) begin
          skip <= skip - 1'b1;
        end else begin
          case (byte_dat)
            PS2_EXT: ext_f <= 1'b1;
            PS2_BRK: brk_f <= 1'b1;
            PS2_PAUSE: begin
              skip  <= PAUSE_SKIP;
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end
            default: begin
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
